// File: rtl/float8_pkg.sv
// Float8 sign-magnitude format constants and the shared fixed-point conversion helper.
package float8_pkg;

  localparam int unsigned F8_SIGN_BIT = 7;
  localparam int unsigned F8_MAG_W    = 7;
  localparam logic [7:0]  F8_OVF_CODE = 8'h80;
  localparam logic [7:0]  F8_ZERO     = 8'h00;

  // Returns the code as a two's-complement value in units of 1/128, masked to `width` bits.
  function automatic logic [31:0] f8_to_fix(input logic [7:0] code, input int unsigned width);
    logic [31:0] mag;
    logic [31:0] val;
    logic [31:0] mask;
    mag = 32'(code[F8_MAG_W-1:0]);
    if (code == F8_OVF_CODE)          val = 32'd128;
    else if (code == F8_ZERO)         val = '0;
    else if (code[F8_SIGN_BIT])       val = -mag;
    else                              val = mag;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return val & mask;
  endfunction

endpackage

// File: rtl/float8_unpacker_if.sv
// Input word handshake, converted-result handshake and overflow count of the Float8 unpacker.
interface float8_unpacker_if #(
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic [7:0]       iNum;
  logic             iValid;
  logic             oReady;
  logic [OUT_W-1:0] oData;
  logic             oOvf;
  logic             oValid;
  logic             iReady;
  logic [CNT_W-1:0] oOvfCnt;

  modport master (output iNum, iValid, iReady,
                  input  oReady, oData, oOvf, oValid, oOvfCnt);
  modport slave  (input  iNum, iValid, iReady,
                  output oReady, oData, oOvf, oValid, oOvfCnt);
endinterface

// File: rtl/float8_fifo.sv
// Generic synchronous FIFO with flush; head reads zero while empty.
module float8_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_en, pop_en;

  assign full    = (occ_q == OCC_W'(DEPTH));
  assign empty   = (occ_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
      end
      if (pop_en) rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      occ_d = OCC_W'(occ_q + OCC_W'(push_en) - OCC_W'(pop_en));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  a_occ_bound:  assert property (@(posedge clk) disable iff (!rst_n) occ_q <= OCC_W'(DEPTH));
  a_no_ovr:     assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_undr:    assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/float8_unpacker.sv
// Float8 receive path: converts words to two's complement, buffers them and counts overflow codes.
module float8_unpacker
  import float8_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iFlush,
  float8_unpacker_if.slave  bus
);
  localparam int unsigned ENT_W = OUT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             full, empty;
  logic             push_c, pop_c, is_ovf_c;
  logic [ENT_W-1:0] entry_c, head;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Flush wins over any handshake in the same cycle.
  assign is_ovf_c = (bus.iNum == F8_OVF_CODE);
  assign push_c   = bus.iValid && !full && !iFlush;
  assign pop_c    = !empty && bus.iReady && !iFlush;
  assign entry_c  = {is_ovf_c, OUT_W'(f8_to_fix(bus.iNum, OUT_W))};

  float8_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (iClk),
    .rst_n (iRst_n),
    .flush (iFlush),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (entry_c),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.oReady  = !full;
  assign bus.oValid  = !empty;
  assign bus.oData   = head[OUT_W-1:0];
  assign bus.oOvf    = head[OUT_W];
  assign bus.oOvfCnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (iFlush)                                    cnt_d = '0;
    else if (push_c && is_ovf_c && cnt_q != CNT_MAX) cnt_d = CNT_W'(cnt_q + 1'b1);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule
